// File: rtl/onehot_key_encoder.sv
// Purpose : debounced 8-bit one-hot key vector to 3-bit code encoder with valid/ready output.
// Latency : in_vec steady before edge 1 -> out_valid rises on edge STABLE_CYC+3 (2 sync + 1 capture + STABLE_CYC qualify).
// Backpres: out_valid/out_code hold until out_ready; input is ignored while a code is pending.
//
// Ports
//   sys_clk    in   1  single clock, rising edge
//   sys_rst_n  in   1  asynchronous assert, active-low reset
//   in_vec     in   8  raw key vector (asynchronous), bit i = key i pressed
//   out_ready  in   1  consumer accepts out_code on an edge where out_valid=1
//   out_code   out  3  index of the pressed key
//   out_valid  out  1  out_code valid, held until accepted
//   err_multi  out  1  one-cycle pulse when the qualified vector is multi-hot
//   busy       out  1  high whenever the FSM is not idle
//
// Build option: define PRIORITY_EN to encode a multi-hot vector as its highest
// set bit instead of flagging it; err_multi is then constantly 0.

module onehot_key_encoder #(
  parameter int unsigned STABLE_CYC = 4,
  parameter int unsigned CNT_W      = 8
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [7:0] in_vec,
  input  logic       out_ready,
  output logic [2:0] out_code,
  output logic       out_valid,
  output logic       err_multi,
  output logic       busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_QUAL = 2'd1,
    S_PEND = 2'd2,
    S_REL  = 2'd3
  } state_t;

  // Synchroniser and control state
  logic [7:0]       r_sync1;
  logic [7:0]       r_sv;
  logic [7:0]       r_cand;
  logic [CNT_W-1:0] r_cnt;
  state_t           r_state;

  // Registered outputs
  logic [2:0]       r_code;
  logic             r_valid;
  logic             r_err;
  logic             r_busy;

  logic             w_cnt_done;
  logic             w_multi;
  logic [2:0]       w_hi_idx;

  assign w_cnt_done = (r_cnt == CNT_LAST);

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign w_multi = |(r_cand & (r_cand - 8'd1));

  // Highest set bit of the candidate; for a one-hot candidate this is simply its index.
  always_comb begin
    w_hi_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (r_cand[i]) begin
        w_hi_idx = 3'(i);
      end
    end
  end

  // Two-flop synchroniser: in_vec is unrelated to sys_clk.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_sync1 <= 8'd0;
      r_sv    <= 8'd0;
    end else begin
      r_sync1 <= in_vec;
      r_sv    <= r_sync1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= S_IDLE;
      r_cand  <= 8'd0;
      r_cnt   <= '0;
      r_code  <= 3'd0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      // Error flag is a single-cycle pulse from the evaluating edge.
      r_err <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (r_sv != 8'd0) begin
            r_cand  <= r_sv;
            r_cnt   <= '0;
            r_state <= S_QUAL;
            r_busy  <= 1'b1;
          end
        end

        S_QUAL: begin
          if (r_sv != r_cand) begin
            // Any change restarts the stability window on the new value.
            r_cand <= r_sv;
            r_cnt  <= '0;
          end else if (!w_cnt_done) begin
            r_cnt <= r_cnt + CNT_ONE;
          end else if (r_cand == 8'd0) begin
            // Bounced back to nothing: treat as no press.
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (!w_multi) begin
            r_code  <= w_hi_idx;
            r_valid <= 1'b1;
            r_state <= S_PEND;
          end else begin
`ifdef PRIORITY_EN
            r_code  <= w_hi_idx;
            r_valid <= 1'b1;
            r_state <= S_PEND;
`else
            r_err   <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_REL;
`endif
          end
        end

        S_PEND: begin
          // Code and valid are frozen here; the key vector is not looked at.
          if (r_valid && out_ready) begin
            r_valid <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_REL;
          end
        end

        S_REL: begin
          // A full window of all-released keys is needed before re-arming,
          // so a key that stays down never produces a second code.
          if (r_sv != 8'd0) begin
            r_cnt <= '0;
          end else if (!w_cnt_done) begin
            r_cnt <= r_cnt + CNT_ONE;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_code  = r_code;
  assign out_valid = r_valid;
  assign err_multi = r_err;
  assign busy      = r_busy;

endmodule

// File: tb/tb_onehot_key_encoder.sv
// Purpose : self-checking bench for onehot_key_encoder (scoreboard queue + monitor).
// Latency : inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpres: bench drives out_ready directly, including long stalls and held-high.

module tb_onehot_key_encoder;

  logic       sys_clk;
  logic       sys_rst_n;
  logic [7:0] in_vec;
  logic       out_ready;
  logic [2:0] out_code;
  logic       out_valid;
  logic       err_multi;
  logic       busy;

  int checks = 0;
  int errors = 0;

  // Expected events: 0..7 = a code transfer, 8 = an err_multi pulse.
  int exp_q[$];
  localparam int EV_ERR = 8;

  onehot_key_encoder dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .in_vec    (in_vec),
    .out_ready (out_ready),
    .out_code  (out_code),
    .out_valid (out_valid),
    .err_multi (err_multi),
    .busy      (busy)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Monitor: a transfer is an edge with valid&ready; sampled half a cycle before it.
  logic err_prev = 1'b0;
  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_transfer: got code %0d, expected no transfer", out_code);
        end else begin
          int e;
          e = exp_q.pop_front();
          if (e != int'(out_code)) begin
            errors++;
            $display("FAIL transfer_code: got %0d (event), expected %0d", out_code, e);
          end
        end
      end
      if (err_multi) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_err_multi: got err_multi=1, expected none");
        end else begin
          int e;
          e = exp_q.pop_front();
          if (e != EV_ERR) begin
            errors++;
            $display("FAIL err_event: got err_multi pulse, expected code %0d", e);
          end
        end
        checks++;
        if (err_prev) begin
          errors++;
          $display("FAIL err_width: err_multi high 2+ cycles, expected 1");
        end
      end
      err_prev = err_multi;
    end else begin
      err_prev = 1'b0;
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Wait (bounded) until every queued event has been seen by the monitor.
  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d events pending, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    tick();
  endtask

  // Release all keys long enough for the release window to complete.
  task automatic release_keys(input string name);
    in_vec = 8'h00;
    repeat (8) tick();
    check({name, "_idle_busy"}, int'(busy), 0);
  endtask

  initial begin
    int k;
    int lat;

    sys_rst_n = 1'b0;
    in_vec    = 8'h10;
    out_ready = 1'b0;

    // 1 Reset values, then first-transaction latency
    repeat (3) tick();
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_code", int'(out_code), 0);
    check("rst_err_multi", int'(err_multi), 0);
    check("rst_busy", int'(busy), 0);

    sys_rst_n = 1'b1;
    exp_q.push_back(4);
    lat = -1;
    for (k = 1; k <= 20; k++) begin
      tick();
      if (out_valid && lat < 0) lat = k;
    end
    check("latency_edge", lat, 7);
    check("first_code", int'(out_code), 4);
    check("pend_busy", int'(busy), 1);

    // 2 Stall: valid and code must stay put
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_valid", int'(out_valid), 1);
      check("stall_code", int'(out_code), 4);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("accept_valid_low", int'(out_valid), 0);
    check("accept_drained", exp_q.size(), 0);
    // Key still held: with ready high any re-trigger would be caught by the monitor.
    out_ready = 1'b1;
    repeat (20) tick();
    check("held_no_revalid", int'(out_valid), 0);
    release_keys("rel1");

    exp_q.push_back(0);
    in_vec = 8'h01;
    wait_drain("key0");
    release_keys("rel2");

    // 3 Debounce: change during qualification, then a one-cycle glitch
    exp_q.push_back(3);
    in_vec = 8'h04;
    repeat (2) tick();
    in_vec = 8'h08;
    wait_drain("debounce");
    release_keys("rel3");

    in_vec = 8'h20;
    tick();
    in_vec = 8'h00;
    repeat (15) tick();
    check("glitch_idle_busy", int'(busy), 0);
    check("glitch_no_valid", int'(out_valid), 0);

    // 4 Multi-hot
`ifdef PRIORITY_EN
    exp_q.push_back(7);
`else
    exp_q.push_back(EV_ERR);
`endif
    in_vec = 8'h90;
    wait_drain("multihot");
    check("multihot_valid", int'(out_valid), 0);
    release_keys("rel4");

    // 5 Reset while a code is pending
    out_ready = 1'b0;
    in_vec = 8'h20;
    k = 0;
    while (!out_valid && k < 30) begin
      tick();
      k++;
    end
    check("pend5_valid", int'(out_valid), 1);
    check("pend5_code", int'(out_code), 5);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("async_rst_valid", int'(out_valid), 0);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_code", int'(out_code), 0);
    tick();
    tick();
    sys_rst_n = 1'b1;
    exp_q.push_back(5);
    out_ready = 1'b1;
    wait_drain("after_reset");
    release_keys("rel5");

    // 6 Sweep all one-hot keys
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(i);
      in_vec = 8'(1 << i);
      wait_drain("sweep");
      release_keys("rel_sweep");
    end

    check("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
